mem_burst_master: RTL and testbench
===================================

Name: mem_burst_master

Overview:
- Initiator-side controller that drives the single-port-pair main memory (512x16, combinational read, posedge write) on behalf of the L1 cache.
- Cache issues block-granular fill, writeback, or writeback+fill (eviction) requests.
- Block sequences per-word memory accesses, assembles fill data, returns one completion pulse.
- Sits between the 2-way L1 cache controller and the 512x16 memory.

Parameters:
- ADDR_W, 9, memory word address width.
- DATA_W, 16, memory word width.
- BLOCK_WORDS, 2, words per cache block; power of two, >=2.
- OFF_W, $clog2(BLOCK_WORDS), word-offset width (derived; not overridable).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache request present.
- req_ready  out  1  high only in IDLE; request accepted on req_valid&&req_ready.
- req_op  in  2  0=fill, 1=writeback, 2=writeback then fill, 3=illegal.
- req_fill_addr  in  ADDR_W  any word address inside the block to fetch.
- req_wb_addr  in  ADDR_W  any word address inside the block to write back.
- req_wb_block  in  DATA_W*BLOCK_WORDS  writeback data; word i at bits [i*DATA_W +: DATA_W].
- resp_done  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_done; 1 only for op 3.
- fill_block  out  DATA_W*BLOCK_WORDS  assembled fill data, same packing as req_wb_block.
- busy  out  1  high in every state except IDLE.
- mem_addr_read  out  ADDR_W  to memory read address.
- mem_readed  in  DATA_W  memory combinational read data.
- mem_write  out  1  memory write enable.
- mem_addr_write  out  ADDR_W  memory write address.
- mem_data_write  out  DATA_W  memory write data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, all latched addresses and data cleared.
  - fill_block=0, resp_done=0, resp_err=0, busy=0.
  - mem_write=0, all mem_* address/data outputs 0.
  - Reset mid-operation aborts immediately: mem_write drops asynchronously, no resp_done is issued, fill_block clears.
- States: IDLE, WRITE, READ, DONE. idx is an OFF_W-bit beat counter.
- Accept (IDLE, req_valid=1):
  - Latch op and req_wb_block.
  - Latch block-aligned bases: address with the low OFF_W bits forced to 0.
  - idx<=0.
  - Next state: op 0 -> READ; op 1 or 2 -> WRITE; op 3 -> DONE.
- WRITE:
  - mem_write=1, mem_addr_write={wb_base[ADDR_W-1:OFF_W], idx}, mem_data_write=wb word idx.
  - idx increments each cycle.
  - On idx=BLOCK_WORDS-1: op 1 -> DONE; op 2 -> READ with idx<=0.
- READ:
  - mem_addr_read={fill_base[ADDR_W-1:OFF_W], idx}.
  - Each edge captures fill word idx <= mem_readed.
  - On idx=BLOCK_WORDS-1 -> DONE.
- Outside their own states: mem_write=0, mem_addr_write=0, mem_data_write=0, mem_addr_read=0.
- DONE: resp_done=1 for exactly one cycle, resp_err=(op==3), then IDLE.
- fill_block:
  - Updated only during READ.
  - Held stable from DONE until the next READ; not cleared by writeback-only ops.
  - Op 1 and op 3 leave it unchanged.
- Latency, accept at edge T: op 0 or op 1 -> resp_done in cycle T+BLOCK_WORDS+1; op 2 -> T+2*BLOCK_WORDS+1; op 3 -> T+1.
- Hazard: for op 2 with identical wb and fill blocks, every write completes before the first read, so fill returns the just-written data (no bypass logic needed).
- req_valid is ignored while busy. No back-to-back accept in the DONE cycle; earliest next accept is the cycle after DONE.
- Address wrap: block base at 2^ADDR_W-BLOCK_WORDS is legal. idx never carries into the base bits.

Decomposition:
- Shared package mem_if_pkg:
  - ADDR_W and DATA_W constants.
  - op encodings OP_FILL, OP_WB, OP_WB_FILL.
  - state enum.
- One natural sub-module, mem_beat_counter: OFF_W counter with clear, enable and last-beat flag, used by both WRITE and READ.

Test Plan:
- Memory preloaded mem[0]=1, mem[1]=3, mem[34]=7, mem[35]=15.
- Fill, req_fill_addr=35 -> mem_addr_read 34 then 35; resp_done at T+3; fill_block={16'd15,16'd7}; resp_err=0.
- Writeback, req_wb_addr=256, block={16'hBEEF,16'hCAFE} -> mem_write high 2 cycles, writes 256<=CAFE then 257<=BEEF; resp_done at T+3; fill_block unchanged.
- Writeback+fill with wb=34 and fill=0 -> writes 34/35, then reads 0/1; fill_block={3,1}; resp_done at T+5. Repeat with fill=34 -> fill_block equals the written data.
- Op 3 -> no mem_write, resp_done with resp_err=1 at T+1. req_valid held high during a fill -> second request accepted only after DONE.
- Assert rst_n low during WRITE beat 0 -> mem_write=0 immediately, only beat 0 or nothing written, no resp_done; after release req_ready=1 and a fill completes normally.
- Edge block, fill at 511 -> reads 510 and 511, no wrap into 0; req_ready low throughout busy.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared constants for the L1-to-main-memory burst path: memory geometry,
// request op encodings and burst master state codes.
package mem_if_pkg;

  localparam int MEM_ADDR_W      = 9;
  localparam int MEM_DATA_W      = 16;
  localparam int MEM_BLOCK_WORDS = 2;

  localparam logic [1:0] OP_FILL    = 2'd0;
  localparam logic [1:0] OP_WB      = 2'd1;
  localparam logic [1:0] OP_WB_FILL = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_beat_counter.sv
// Word-offset counter within a block. Clear wins over enable; last is high
// on the final beat. This works because the block size is a power of two.
module mem_beat_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = &cnt;

endmodule

// File: rtl/mem_burst_master.sv
// Block-granular memory initiator for the L1 cache. It sequences per-word
// writebacks and fills, and signals each request with one completion pulse.
module mem_burst_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int BLOCK_WORDS = MEM_BLOCK_WORDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [ADDR_W-1:0]             req_fill_addr,
  input  logic [ADDR_W-1:0]             req_wb_addr,
  input  logic [DATA_W*BLOCK_WORDS-1:0] req_wb_block,
  output logic                          resp_done,
  output logic                          resp_err,
  output logic [DATA_W*BLOCK_WORDS-1:0] fill_block,
  output logic                          busy,
  output logic [ADDR_W-1:0]             mem_addr_read,
  input  logic [DATA_W-1:0]             mem_readed,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr_write,
  output logic [DATA_W-1:0]             mem_data_write
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int BLK_W = DATA_W * BLOCK_WORDS;

  logic [1:0]       state, state_nxt;
  logic [1:0]       op_q;
  logic [BLK_W-1:0] wb_block_q;
  logic [TAG_W-1:0] wb_tag_q, fill_tag_q;
  logic [OFF_W-1:0] idx;
  logic             last;
  logic             cnt_clr, cnt_en;
  logic             accept;
  logic             unused_offsets;

  // Handshake: a request transfers on the rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so the request
  // fields need to be stable only in that cycle.
  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != ST_IDLE);

  // Only block-aligned bases are stored, so the word offset never reaches the tag.
  assign unused_offsets = ^{req_wb_addr[OFF_W-1:0], req_fill_addr[OFF_W-1:0]};

  mem_beat_counter #(.WIDTH(OFF_W)) u_beat (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (idx),
    .last (last)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_clr = 1'b1;
          case (req_op)
            OP_FILL:           state_nxt = ST_READ;
            OP_WB, OP_WB_FILL: state_nxt = ST_WRITE;
            default:           state_nxt = ST_DONE;
          endcase
        end
      end
      ST_WRITE: begin
        cnt_en = 1'b1;
        if (last) begin
          if (op_q == OP_WB_FILL) begin
            state_nxt = ST_READ;
            cnt_clr   = 1'b1;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_READ: begin
        cnt_en = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      wb_block_q <= '0;
      wb_tag_q   <= '0;
      fill_tag_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= req_op;
        wb_block_q <= req_wb_block;
        wb_tag_q   <= req_wb_addr[ADDR_W-1:OFF_W];
        fill_tag_q <= req_fill_addr[ADDR_W-1:OFF_W];
      end
    end
  end

  // Fill data persists across writeback-only and illegal ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_block <= '0;
    end else if (state == ST_READ) begin
      fill_block[int'(idx)*DATA_W +: DATA_W] <= mem_readed;
    end
  end

  assign mem_write      = (state == ST_WRITE);
  assign mem_addr_write = mem_write ? {wb_tag_q, idx} : '0;
  assign mem_data_write = mem_write ? wb_block_q[int'(idx)*DATA_W +: DATA_W] : '0;
  assign mem_addr_read  = (state == ST_READ) ? {fill_tag_q, idx} : '0;

  assign resp_done = (state == ST_DONE);
  assign resp_err  = resp_done && (op_q == OP_ILLEGAL);

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural 512x16 memory and a
// scoreboard of expected writes, reads and completions.
module tb_mem_burst_master;
  import mem_if_pkg::*;

  localparam int AW  = 9;
  localparam int DW  = 16;
  localparam int BLK = 32;

  logic           clk, rst_n;
  logic           req_valid, req_ready;
  logic [1:0]     req_op;
  logic [AW-1:0]  req_fill_addr, req_wb_addr;
  logic [BLK-1:0] req_wb_block, fill_block;
  logic           resp_done, resp_err, busy;
  logic [AW-1:0]  mem_addr_read, mem_addr_write;
  logic [DW-1:0]  mem_readed, mem_data_write;
  logic           mem_write;

  mem_burst_master dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_fill_addr (req_fill_addr),
    .req_wb_addr   (req_wb_addr),
    .req_wb_block  (req_wb_block),
    .resp_done     (resp_done),
    .resp_err      (resp_err),
    .fill_block    (fill_block),
    .busy          (busy),
    .mem_addr_read (mem_addr_read),
    .mem_readed    (mem_readed),
    .mem_write     (mem_write),
    .mem_addr_write(mem_addr_write),
    .mem_data_write(mem_data_write)
  );

  // clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:511];
  assign mem_readed = mem[mem_addr_read];
  always @(posedge clk) if (mem_write) mem[mem_addr_write] <= mem_data_write;

  // scoreboard
  logic [40:0]   exp_q[$];  // {err, fill_block, latency}
  logic [24:0]   wr_q[$];   // {addr, data}
  logic [AW-1:0] rd_q[$];
  int checks = 0, errors = 0;
  int neg_cnt = 0, acc_neg = 0, done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [40:0] e;
    logic [24:0] w;
    logic [AW-1:0] r;
    neg_cnt++;
    if (rst_n) begin
      if (busy) chk("ready_low_busy", {63'd0, req_ready}, 64'd0);
      if (mem_write) begin
        if (wr_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
        else begin
          w = wr_q.pop_front();
          chk("write", {39'd0, mem_addr_write, mem_data_write}, {39'd0, w});
        end
      end
      if (busy && !mem_write && !resp_done) begin
        if (rd_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
        else begin
          r = rd_q.pop_front();
          chk("read_addr", {55'd0, mem_addr_read}, {55'd0, r});
        end
      end
      if (resp_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("resp_err", {63'd0, resp_err}, {63'd0, e[40]});
          chk("fill_block", {32'd0, fill_block}, {32'd0, e[39:8]});
          chk("latency", 64'(neg_cnt - acc_neg), {56'd0, e[7:0]});
        end
        done_cnt++;
      end
      if (req_valid && req_ready) acc_neg = neg_cnt;
    end
  end

  // driver tasks
  task automatic wait_done(input int tgt);
    int n = 0;
    while (done_cnt < tgt && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < tgt) chk("done_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] fa, input logic [AW-1:0] wa,
                       input logic [BLK-1:0] blk, input int lat, input logic err,
                       input logic [BLK-1:0] exp_fill);
    int n = 0;
    int tgt = done_cnt + 1;
    exp_q.push_back({err, exp_fill, 8'(lat)});
    req_op = op; req_fill_addr = fa; req_wb_addr = wa; req_wb_block = blk;
    req_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done(tgt);
  endtask

  initial begin
    int tgt;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0] = 16'd1; mem[1] = 16'd3; mem[34] = 16'd7; mem[35] = 16'd15;
    mem[510] = 16'h1510; mem[511] = 16'h1511;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0;
    req_fill_addr = '0; req_wb_addr = '0; req_wb_block = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, resp_done}, 64'd0);
    chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_fill", {32'd0, fill_block}, 64'd0);
    chk("rst_addr_read", {55'd0, mem_addr_read}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // fill from address 35
    rd_q.push_back(9'd34); rd_q.push_back(9'd35);
    issue(OP_FILL, 9'd35, 9'd0, 32'd0, 3, 1'b0, {16'd15, 16'd7});

    // writeback to 256; fill_block unchanged
    wr_q.push_back({9'd256, 16'hCAFE}); wr_q.push_back({9'd257, 16'hBEEF});
    issue(OP_WB, 9'd0, 9'd256, {16'hBEEF, 16'hCAFE}, 3, 1'b0, {16'd15, 16'd7});
    chk("mem256", {48'd0, mem[256]}, 64'hCAFE);
    chk("mem257", {48'd0, mem[257]}, 64'hBEEF);

    // writeback 34 (unaligned addr) then fill 0 (unaligned addr)
    wr_q.push_back({9'd34, 16'h5A5A}); wr_q.push_back({9'd35, 16'hA5A5});
    rd_q.push_back(9'd0); rd_q.push_back(9'd1);
    issue(OP_WB_FILL, 9'd1, 9'd35, {16'hA5A5, 16'h5A5A}, 5, 1'b0, {16'd3, 16'd1});

    // same block: fill returns the data just written
    wr_q.push_back({9'd34, 16'h1111}); wr_q.push_back({9'd35, 16'h2222});
    rd_q.push_back(9'd34); rd_q.push_back(9'd35);
    issue(OP_WB_FILL, 9'd34, 9'd34, {16'h2222, 16'h1111}, 5, 1'b0, {16'h2222, 16'h1111});

    // illegal op
    issue(OP_ILLEGAL, 9'd100, 9'd200, 32'hDEAD_BEEF, 1, 1'b1, {16'h2222, 16'h1111});

    // req_valid held high across two fills
    tgt = done_cnt + 2;
    repeat (2) begin
      rd_q.push_back(9'd34); rd_q.push_back(9'd35);
      exp_q.push_back({1'b0, 16'h2222, 16'h1111, 8'd3});
    end
    req_op = OP_FILL; req_fill_addr = 9'd35; req_valid = 1'b1;
    begin
      int n = 0;
      while (done_cnt < tgt && n < 100) begin
        @(posedge clk);
        n++;
      end
      if (done_cnt < tgt) chk("held_timeout", 64'd1, 64'd0);
    end
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;

    // reset during WRITE beat 0
    req_op = OP_WB; req_wb_addr = 9'd100; req_wb_block = {16'hBBBB, 16'hAAAA};
    req_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_in_write", {63'd0, mem_write}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write", {63'd0, mem_write}, 64'd0);
    chk("abort_done", {63'd0, resp_done}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_fill", {32'd0, fill_block}, 64'd0);
    repeat (2) @(posedge clk);
    chk("abort_word1", {48'd0, mem[101]}, 64'd0);
    #1 rst_n = 1'b1;
    chk("abort_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;

    rd_q.push_back(9'd34); rd_q.push_back(9'd35);
    issue(OP_FILL, 9'd34, 9'd0, 32'd0, 3, 1'b0, {16'h2222, 16'h1111});

    // top-of-memory block, no wrap
    rd_q.push_back(9'd510); rd_q.push_back(9'd511);
    issue(OP_FILL, 9'd511, 9'd0, 32'd0, 3, 1'b0, {16'h1511, 16'h1510});

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
